decoder_scan_seq: RTL



---
 rtl/decoder_scan_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: N-to-2^N decoder with active-low, registered one-hot-low
// outputs and an auto-scan mode that steps an internal index through
// [SCAN_FIRST, SCAN_LAST] once every SCAN_DIV clock cycles.
module decoder_scan_seq #(
    parameter int N          = 4,
    parameter int SCAN_DIV   = 4,
    parameter int SCAN_FIRST = 0,
    parameter int SCAN_LAST  = 2**N - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic              mode,
    input  logic [N-1:0]      S,
    input  logic              load,
    input  logic              hold,
    output logic [2**N-1:0]   W_n,
    output logic [N-1:0]      cur_sel,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PC_MAX    = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PC_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0] PC_ONE    = PW'(1);
    localparam logic [N-1:0]  IDX_FIRST = N'(SCAN_FIRST);
    localparam logic [N-1:0]  IDX_LAST  = N'(SCAN_LAST);
    localparam logic [N-1:0]  IDX_ONE   = N'(1);
    localparam logic [W-1:0]  ONE_HOT0  = W'(1);
    localparam logic [W-1:0]  ALL_OFF   = {W{1'b1}};

    logic [N-1:0]  idx_q,     idx_d;
    logic [PW-1:0] pc_q,      pc_d;
    logic          mode_q,    mode_d;
    logic [W-1:0]  w_n_q,     w_n_d;
    logic [N-1:0]  cur_sel_q, cur_sel_d;
    logic          wrap_q,    wrap_d;

    logic [PW-1:0] pc_base;
    logic [N-1:0]  sel;

    // Next-state logic: scan index/prescaler update and decoded output word.
    always_comb begin
        idx_d   = idx_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
        mode_d  = mode;
        sel     = S;
        // Entering scan mode restarts the prescaler so the held index gets a full period.
        if (mode_q) begin
            pc_base = pc_q;
        end else begin
            pc_base = PC_ZERO;
        end

        if (mode) begin
            if (load) begin
                idx_d = S;
                pc_d  = PC_ZERO;
            end else if (hold) begin
                idx_d = idx_q;
                pc_d  = pc_base;
            end else if (pc_base == PC_MAX) begin
                pc_d = PC_ZERO;
                // Indices above the range (from a load) wrap on the next step too.
                if (idx_q >= IDX_LAST) begin
                    idx_d  = IDX_FIRST;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else begin
                pc_d = pc_base + PC_ONE;
            end
            sel = idx_d;
        end else begin
            idx_d = idx_q;
            pc_d  = pc_q;
            sel   = S;
        end

        cur_sel_d = sel;
        if (en_n) begin
            w_n_d = ALL_OFF;
        end else begin
            w_n_d = ~(ONE_HOT0 << sel);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= IDX_FIRST;
            pc_q      <= PC_ZERO;
            mode_q    <= 1'b0;
            w_n_q     <= ALL_OFF;
            cur_sel_q <= {N{1'b0}};
            wrap_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            pc_q      <= pc_d;
            mode_q    <= mode_d;
            w_n_q     <= w_n_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
        end
    end

    assign W_n     = w_n_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule
